bsort_ctrl: RTL
===============

# bsort_ctrl

Sequencing controller for the bubble-sort datapath; it sits directly upstream of the 2-read/2-write register file and drives all of its control and write-data ports. It shifts N values into the register file through the serial-load chain. It then runs bubble-sort passes, comparing adjacent entries and writing them back swapped when out of order, with early exit on a swap-free pass. Finally it streams the sorted values out in ascending order over a valid/ready handshake.

## Interface
- WIDTH, 8, data width; matches register-file entry width.
- N, 8, number of entries to sort; 2 <= N <= 2**IDXW.
- IDXW, 3, register-file index width.

Clocking: one clock `clk`. Reset `rst` is synchronous and active-high.

- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  begin a load/sort/unload job; sampled only in IDLE.
- in_valid  in  1  input beat valid.
- in_data  in  WIDTH  input value.
- in_ready  out  1  high throughout LOAD.
- out_valid  out  1  sorted value available.
- out_data  out  WIDTH  sorted value; driven combinationally from rf_aout.
- out_ready  in  1  consumer accepts beat.
- out_last  out  1  high with the final (largest) beat.
- busy  out  1  high in LOAD, SORT and UNLOAD.
- sorted  out  1  one-cycle pulse when SORT completes.
- rf_qin  out  1  shift-load enable into register entry 0.
- rf_data  out  WIDTH  shift-load data; equals in_data.
- rf_w_en  out  1  swap write enable.
- rf_aindex  out  IDXW  read/write index A.
- rf_bindex  out  IDXW  read/write index B.
- rf_dina  out  WIDTH  write data for index A.
- rf_dinb  out  WIDTH  write data for index B.
- rf_aout  in  WIDTH  register-file read data at rf_aindex; combinational.
- rf_bout  in  WIDTH  register-file read data at rf_bindex; combinational.

## Operation
- States: IDLE, LOAD, SORT, UNLOAD.
- Reset: state goes to IDLE and all counters clear.
  - All outputs are 0 except rf_data, which follows in_data.
  - Register-file contents are not cleared.
- IDLE: when start is high, go to LOAD with load count cnt = 0. Indices are 0 and rf_w_en = 0.
- LOAD:
  - in_ready = 1 and rf_qin = in_valid.
  - Each beat where in_valid is high shifts the chain: entry0 takes in_data, and entry k takes entry k-1.
  - cnt increments per beat; a cycle with in_valid low leaves the chain and cnt unchanged.
  - After beat N-1, go to SORT with pass p = 0, position j = 0 and flag swapped = 0.
- SORT (one compare per cycle):
  - rf_aindex = j, rf_bindex = j+1.
  - If rf_aout > rf_bout (unsigned): rf_w_en = 1, rf_dina = rf_bout, rf_dinb = rf_aout, and swapped is set.
  - Equal or in-order values cause no write.
  - If j < N-2-p: j increments.
  - At j == N-2-p (end of pass):
    - If no swap occurred this pass (including the current cycle), or p == N-2: pulse `sorted` and go to UNLOAD with k = 0.
    - Otherwise p increments, j = 0 and swapped = 0.
  - rf_dina/rf_dinb are 0 whenever rf_w_en = 0.
- UNLOAD:
  - rf_aindex = k, out_valid = 1, out_data = rf_aout, out_last = (k == N-1).
  - Each out_ready handshake increments k.
  - The handshake at k == N-1 returns the block to IDLE.
- Result: entry 0 holds the minimum and entry N-1 the maximum, so output order is ascending.
- start is ignored outside IDLE.
- Reset in any state returns to IDLE on the next edge. A partially sorted register file is left as-is.

## Timing
- LOAD: N accepting cycles minimum. No backpressure on the input side beyond in_ready.
- SORT: no bubbles and no stalls.
  - Minimum N-1 cycles (input already in order).
  - Maximum N(N-1)/2 cycles; 28 at N=8.
- Read/compare/write occurs in a single cycle. The write takes effect at the clock edge ending the compare cycle.
- UNLOAD: first out_valid appears in the cycle after the last SORT cycle.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - N cycles minimum.
- busy rises the cycle after start is accepted. It falls the cycle after the final output handshake.

## Test plan
- Arrivals 5,3,8,1,9,2,7,4 -> outputs 1,2,3,4,5,7,8,9; out_last only on 9; one sorted pulse.
- Arrivals 80,70,60,50,40,30,20,10 (entries already ascending) -> exactly 7 SORT cycles, rf_w_en never high, outputs 10..80.
- Arrivals 1..8 (entries descending) -> 28 SORT cycles with rf_w_en high in all 28; outputs 1..8.
- Arrivals 0,255,255,0,128,128,1,254 -> outputs 0,0,1,128,128,254,255,255; no write on any equal-value compare.
- in_valid low every other cycle during LOAD plus random out_ready stalls -> chain shifts only on valid beats; out_data stable under stall; same result as the unstalled run.
- rst asserted at SORT cycle 5 -> IDLE next cycle with all outputs 0; start pulsed during busy is ignored; a fresh job after reset sorts correctly.

Source files
------------

// File: rtl/bsort_ctrl.sv
// bsort_ctrl: load/bubble-sort/unload sequencer driving a 2R/2W register file.
module bsort_ctrl #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data,
  input  logic             i_out_ready,
  output logic             o_out_last,
  output logic             o_busy,
  output logic             o_sorted,
  output logic             o_rf_qin,
  output logic [WIDTH-1:0] o_rf_data,
  output logic             o_rf_w_en,
  output logic [IDXW-1:0]  o_rf_aindex,
  output logic [IDXW-1:0]  o_rf_bindex,
  output logic [WIDTH-1:0] o_rf_dina,
  output logic [WIDTH-1:0] o_rf_dinb,
  input  logic [WIDTH-1:0] i_rf_aout,
  input  logic [WIDTH-1:0] i_rf_bout
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SORT   = 2'd2;
  localparam logic [1:0] S_UNLOAD = 2'd3;
  localparam logic [IDXW-1:0] L_LAST = IDXW'(N - 1);
  localparam logic [IDXW-1:0] L_NM2  = IDXW'(N - 2);
  logic [1:0]      r_state;
  logic [IDXW-1:0] r_cnt, r_p, r_j, r_k;
  logic            r_swapped;
  logic            w_load, w_sort, w_unload, w_gt, w_pass_end, w_done;
  assign w_load     = r_state == S_LOAD;
  assign w_sort     = r_state == S_SORT;
  assign w_unload   = r_state == S_UNLOAD;
  assign w_gt       = i_rf_aout > i_rf_bout;
  assign w_pass_end = r_j == L_NM2 - r_p;
  // a swap in the final compare of a pass still forces another pass
  assign w_done     = w_pass_end && (!(r_swapped || w_gt) || r_p == L_NM2);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_p       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_LOAD;
          r_cnt   <= '0;
        end
        S_LOAD: if (i_in_valid) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == L_LAST) begin
            r_state   <= S_SORT;
            r_p       <= '0;
            r_j       <= '0;
            r_swapped <= 1'b0;
          end
        end
        S_SORT: if (w_done) begin
          r_state <= S_UNLOAD;
          r_k     <= '0;
        end else if (w_pass_end) begin
          r_p       <= r_p + 1'b1;
          r_j       <= '0;
          r_swapped <= 1'b0;
        end else begin
          r_j       <= r_j + 1'b1;
          r_swapped <= r_swapped | w_gt;
        end
        default: if (i_out_ready) begin
          if (r_k == L_LAST) r_state <= S_IDLE;
          else r_k <= r_k + 1'b1;
        end
      endcase
    end
  end
  assign o_in_ready  = w_load;
  assign o_rf_qin    = w_load & i_in_valid;
  assign o_rf_data   = i_in_data;
  assign o_rf_w_en   = w_sort & w_gt;
  assign o_rf_dina   = o_rf_w_en ? i_rf_bout : '0;
  assign o_rf_dinb   = o_rf_w_en ? i_rf_aout : '0;
  assign o_rf_aindex = w_sort ? r_j : w_unload ? r_k : '0;
  assign o_rf_bindex = w_sort ? r_j + 1'b1 : '0;
  assign o_out_valid = w_unload;
  assign o_out_data  = w_unload ? i_rf_aout : '0;
  assign o_out_last  = w_unload && r_k == L_LAST;
  assign o_busy      = r_state != S_IDLE;
  assign o_sorted    = w_sort & w_done;
endmodule
